// File: rtl/flow_sum_pkg.sv
// Shared types and helpers for the flow_sum_n packet accumulator.
package flow_sum_pkg;

  // IDLE: waiting for go; ACC: summing a packet; ERR: summing with overflow latched.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ERR  = 2'd2
  } fs_state_t;

  // All-ones value of the given width (1..64), right-aligned in 64 bits.
  function automatic logic [63:0] sum_max(input int unsigned width);
    return {64{1'b1}} >> (64 - width);
  endfunction

endpackage

// File: rtl/flow_sum_n_if.sv
// Word-stream input and result/status output bundle of flow_sum_n.
// master: word producer / status consumer side; slave: the accumulator.
interface flow_sum_n_if #(
  parameter int W     = 16,
  parameter int CNT_W = 8
);
  logic             go;
  logic             abort;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             busy;
  logic             done;
  logic             error;
  logic [W-1:0]     sum;
  logic [CNT_W-1:0] count;

  modport master (
    output go, abort, in_valid, in_data,
    input  busy, done, error, sum, count
  );

  modport slave (
    input  go, abort, in_valid, in_data,
    output busy, done, error, sum, count
  );
endinterface

// File: rtl/flow_sum_acc.sv
// W-bit accumulator adder with carry detect.
// FLOW_SUM_SAT_EN defined: an overflowing add saturates to all-ones.
// FLOW_SUM_SAT_EN undefined: an overflowing add wraps to the low W bits.
module flow_sum_acc
  import flow_sum_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  logic [W:0] raw;

  assign raw     = {1'b0, acc_i} + {1'b0, add_i};
  assign carry_o = raw[W];

`ifdef FLOW_SUM_SAT_EN
  localparam logic [W-1:0] SUM_MAX = W'(sum_max(W));
  // Once saturated, any further nonzero add carries again, so acc stays pinned.
  assign sum_o = raw[W] ? SUM_MAX : raw[W-1:0];
`else
  assign sum_o = raw[W-1:0];
`endif

endmodule

// File: rtl/flow_sum_n.sv
// Zero-terminated packet accumulator with valid qualifier, element counter,
// abort, and sticky sum/length overflow. Result registers hold until the
// next done. Optional build macro: FLOW_SUM_SAT_EN (saturating sum, see
// flow_sum_acc); default build wraps.
module flow_sum_n
  import flow_sum_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  flow_sum_n_if.slave        bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sum_max(CNT_W));

  fs_state_t        state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             error_q, error_d;

  logic [W-1:0]     acc_next;
  logic             acc_carry;
  logic             word_nz;
  logic             word_term;
  logic             cnt_full;

  assign word_nz   = bus.in_valid && (bus.in_data != '0);
  assign word_term = bus.in_valid && (bus.in_data == '0);
  assign cnt_full  = (cnt_q == CNT_MAX);

  flow_sum_acc #(.W(W)) u_acc (
    .acc_i   (acc_q),
    .add_i   (bus.in_data),
    .sum_o   (acc_next),
    .carry_o (acc_carry)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: abort wins, terminator returns to IDLE, overflow moves to ERR.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (bus.go && word_nz) state_d = ACC;
        ACC, ERR: begin
          if (word_term)                             state_d = IDLE;
          else if (word_nz && (acc_carry || cnt_full)) state_d = ERR;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: busy is a pure decode of the state register.
  always_comb begin
    bus.busy = (state_q != IDLE);
  end

  // Datapath next values: accumulator, counter, sticky overflow and result latch.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    count_d = count_q;
    error_d = error_q;
    if (bus.abort) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.go && bus.in_valid) begin
            acc_d = bus.in_data;
            cnt_d = word_nz ? CNT_W'(1) : '0;
            ovf_d = 1'b0;
            if (word_term) begin
              // Empty packet: report an all-zero result straight away.
              done_d  = 1'b1;
              sum_d   = '0;
              count_d = '0;
              error_d = 1'b0;
            end
          end
        end
        ACC, ERR: begin
          if (word_nz) begin
            acc_d = acc_next;
            cnt_d = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
            ovf_d = ovf_q | acc_carry | cnt_full;
          end else if (word_term) begin
            done_d  = 1'b1;
            sum_d   = acc_q;
            count_d = cnt_q;
            error_d = ovf_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.count = count_q;
  assign bus.error = error_q;

endmodule
